// File: rtl/ifu_fetch.sv
// ifu_fetch: multi-cycle instruction fetch unit. The PC register, a
// FETCH/WAIT/EXEC handshake with instruction memory, the branch condition
// evaluator and the next-PC selector.
// Optional feature macro: IFU_ALIGN_CHECK_EN. When it is defined, a
// misaligned jump target traps into a sticky ERR state. When it is not
// defined, target bits [1:0] are cleared.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC      = 32'h0000_3000,
  parameter int          JUMP_SEG_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic [1:0]  Jumpctr,
  input  logic [2:0]  Branchctr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        addr_err
);

`ifdef IFU_ALIGN_CHECK_EN
  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, EXEC = 2'd2, ERR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, EXEC = 2'd2} state_t;
`endif

  // Upper PC segment kept by j/jal; the remaining bits come from the target field.
  localparam logic [31:0] SEG_MASK = ~(32'hFFFF_FFFF >> JUMP_SEG_BITS);

  state_t      state;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] next_pc_raw;
  logic [31:0] next_pc;
  logic        br_taken;

  assign pc_plus4   = pc + 32'd4;
  assign link_addr  = pc_plus4;
  assign imem_addr  = pc;
  assign br_target  = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jmp_target = (pc_plus4 & SEG_MASK) | ({4'b0000, instr[25:0], 2'b00} & ~SEG_MASK);
  // Gating with rst_n keeps the request low while reset is held. The first
  // cycle after reset release then already requests the fetch.
  assign imem_req   = rst_n & ((state == FETCH) | (state == WAIT));

  // Branch condition evaluation on signed operands (sign bit tests for compare-with-zero).
  always_comb begin
    br_taken = 1'b0;
    case (Branchctr)
      3'b001:  br_taken = (rs_val == rt_val);
      3'b010:  br_taken = (rs_val != rt_val);
      3'b011:  br_taken = ~rs_val[31];
      3'b100:  br_taken = rs_val[31];
      3'b101:  br_taken = ~rs_val[31] & (rs_val != 32'd0);
      3'b110:  br_taken = rs_val[31] | (rs_val == 32'd0);
      default: br_taken = 1'b0;
    endcase
  end

  // Next-PC priority: register jump, segment jump, taken branch, sequential.
  always_comb begin
    next_pc_raw = pc_plus4;
    if (Jumpctr == 2'b10) begin
      next_pc_raw = rs_val;
    end else if (Jumpctr == 2'b01) begin
      next_pc_raw = jmp_target;
    end else if (br_taken) begin
      next_pc_raw = br_target;
    end else begin
      next_pc_raw = pc_plus4;
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  assign next_pc = next_pc_raw;
`else
  assign next_pc  = next_pc_raw & 32'hFFFF_FFFC;
  assign addr_err = 1'b0;
`endif

  // Fetch FSM, PC update and instruction capture, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      addr_err    <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          instr_valid <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end else begin
            instr_valid <= 1'b0;
          end
        end
        EXEC: begin
          instr_valid <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
          if (next_pc[1:0] != 2'b00) begin
            addr_err <= 1'b1;
            state    <= ERR;
          end else begin
            pc    <= next_pc;
            state <= FETCH;
          end
`else
          pc    <= next_pc;
          state <= FETCH;
`endif
        end
`ifdef IFU_ALIGN_CHECK_EN
        ERR: begin
          instr_valid <= 1'b0;
          state       <= ERR;
        end
`endif
        default: begin
          instr_valid <= 1'b0;
          state       <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed, table-driven bench for ifu_fetch, followed by
// hand-written sequences for the multi-cycle handshake and reset cases.
// The alignment-trap checks follow the IFU_ALIGN_CHECK_EN macro.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [1:0]  Jumpctr;
  logic [2:0]  Branchctr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        addr_err;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  j;
    logic [2:0]  b;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] next;
  } vec_t;

  vec_t tbl [25];

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .Jumpctr(Jumpctr), .Branchctr(Branchctr),
    .rs_val(rs_val), .rt_val(rt_val), .pc(pc), .link_addr(link_addr),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    Jumpctr   = 2'b00;
    Branchctr = 3'b000;
    rs_val    = 32'd0;
    rt_val    = 32'd0;
  endtask

  // Runs one instruction. It starts in a FETCH cycle and ends in the next FETCH cycle.
  task automatic run_vec(input vec_t v);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("wait_req", {31'd0, imem_req}, 32'd1);
    chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("exec_instr", instr, v.rdata);
    chk("exec_link", link_addr, exp_pc + 32'd4);
    Jumpctr   = v.j;
    Branchctr = v.b;
    rs_val    = v.rs;
    rt_val    = v.rt;
    tick();
    idle_ctrl();
    chk("post_valid", {31'd0, instr_valid}, 32'd0);
    chk("instr_hold", instr, v.rdata);
    chk("next_pc", pc, v.next);
    exp_pc = v.next;
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0000, 2'b00, 3'b000, 32'h0,         32'h0,         32'h0000_3004};
    tbl[1]  = '{32'h0000_0000, 2'b00, 3'b000, 32'h0,         32'h0,         32'h0000_3008};
    tbl[2]  = '{32'h0000_0000, 2'b10, 3'b000, 32'h0000_3010, 32'h0,         32'h0000_3010};
    tbl[3]  = '{32'h1000_FFFE, 2'b00, 3'b001, 32'h5,         32'h5,         32'h0000_300C};
    tbl[4]  = '{32'h0000_0000, 2'b10, 3'b000, 32'h0000_3010, 32'h0,         32'h0000_3010};
    tbl[5]  = '{32'h1000_FFFE, 2'b00, 3'b001, 32'h5,         32'h6,         32'h0000_3014};
    tbl[6]  = '{32'h0000_0000, 2'b10, 3'b000, 32'h0000_3000, 32'h0,         32'h0000_3000};
    tbl[7]  = '{32'h0400_0004, 2'b00, 3'b100, 32'h8000_0000, 32'h0,         32'h0000_3014};
    tbl[8]  = '{32'h0000_0000, 2'b10, 3'b000, 32'h0000_3000, 32'h0,         32'h0000_3000};
    tbl[9]  = '{32'h1C00_0004, 2'b00, 3'b101, 32'h0,         32'h0,         32'h0000_3004};
    tbl[10] = '{32'h0000_0000, 2'b10, 3'b000, 32'h0000_3000, 32'h0,         32'h0000_3000};
    tbl[11] = '{32'h1800_0004, 2'b00, 3'b110, 32'h0,         32'h0,         32'h0000_3014};
    tbl[12] = '{32'h0000_0000, 2'b10, 3'b000, 32'h0000_3020, 32'h0,         32'h0000_3020};
    tbl[13] = '{32'h0C00_0C10, 2'b01, 3'b000, 32'h0,         32'h0,         32'h0000_3040};
    tbl[14] = '{32'h0000_0000, 2'b10, 3'b000, 32'h0000_3100, 32'h0,         32'h0000_3100};
    tbl[15] = '{32'h1400_0001, 2'b00, 3'b010, 32'h1,         32'h2,         32'h0000_3108};
    tbl[16] = '{32'h0401_0002, 2'b00, 3'b011, 32'h0,         32'h0,         32'h0000_3114};
    tbl[17] = '{32'h0401_0002, 2'b00, 3'b011, 32'hFFFF_FFFF, 32'h0,         32'h0000_3118};
    tbl[18] = '{32'h0000_0010, 2'b00, 3'b111, 32'h0,         32'h0,         32'h0000_311C};
    tbl[19] = '{32'h0000_0000, 2'b11, 3'b000, 32'h0000_5000, 32'h0,         32'h0000_3120};
    tbl[20] = '{32'h1000_0010, 2'b10, 3'b001, 32'h0000_3000, 32'h0000_3000, 32'h0000_3000};
    tbl[21] = '{32'h0000_0000, 2'b10, 3'b000, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC};
    tbl[22] = '{32'h0000_0000, 2'b00, 3'b000, 32'h0,         32'h0,         32'h0000_0000};
    tbl[23] = '{32'h0800_0400, 2'b01, 3'b001, 32'h0,         32'h0,         32'h0000_1000};
    tbl[24] = '{32'h0000_0000, 2'b10, 3'b000, 32'h0000_3050, 32'h0,         32'h0000_3050};

    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    idle_ctrl();
    tick();
    tick();
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    exp_pc = 32'h0000_3000;

    for (int i = 0; i < 25; i++) begin
      run_vec(tbl[i]);
    end

    // Ack already high in FETCH: the FSM still spends one cycle in WAIT.
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_1111;
    tick();
    chk("early_ack_wait_valid", {31'd0, instr_valid}, 32'd0);
    chk("early_ack_wait_req", {31'd0, imem_req}, 32'd1);
    tick();
    imem_ack = 1'b0;
    chk("early_ack_exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("early_ack_instr", instr, 32'h1111_1111);
    tick();
    chk("early_ack_next_pc", imem_addr, 32'h0000_3054);

    // Ack delayed in WAIT, then reset abandons the fetch. A stray ack follows.
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("wait_hold_req", {31'd0, imem_req}, 32'd1);
      chk("wait_hold_addr", imem_addr, 32'h0000_3054);
      chk("wait_hold_valid", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h2222_2222;
    tick();
    chk("wait_rst_pc", pc, 32'h0000_3000);
    chk("wait_rst_req", {31'd0, imem_req}, 32'd0);
    chk("wait_rst_instr", instr, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_req_after_rst", {31'd0, imem_req}, 32'd1);
    chk("first_addr_after_rst", imem_addr, 32'h0000_3000);
    tick();
    imem_ack = 1'b0;
    chk("stray_ack_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("stray_ack_still_wait", {31'd0, instr_valid}, 32'd0);
    chk("stray_ack_instr", instr, 32'd0);
    chk("stray_ack_addr", imem_addr, 32'h0000_3000);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0000;
    tick();
    imem_ack = 1'b0;
    chk("fresh_fetch_valid", {31'd0, instr_valid}, 32'd1);
    tick();
    chk("fresh_fetch_next", imem_addr, 32'h0000_3004);

    // Misaligned register-jump target.
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0000;
    tick();
    imem_ack  = 1'b0;
    Jumpctr   = 2'b10;
    rs_val    = 32'h0000_3102;
    tick();
    idle_ctrl();
`ifdef IFU_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      chk("align_err_flag", {31'd0, addr_err}, 32'd1);
      chk("align_err_req", {31'd0, imem_req}, 32'd0);
      chk("align_err_valid", {31'd0, instr_valid}, 32'd0);
      chk("align_err_pc", pc, 32'h0000_3004);
      imem_ack = 1'b1;
      tick();
    end
    imem_ack = 1'b0;
`else
    chk("align_force_pc", pc, 32'h0000_3100);
    chk("align_no_err", {31'd0, addr_err}, 32'd0);
    chk("align_req", {31'd0, imem_req}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
